// File: rtl/wb_arb_pkg.sv
// Shared widths and the buffered write-request type for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Register 0 is hard-wired, so a write to it is consumed but never reaches the file.
    function automatic logic addr_writable(input logic [REG_ADDR_W-1:0] addr);
        return addr != {REG_ADDR_W{1'b0}};
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Wrap-around pointer FIFO holding mul/div write requests until they win the register-file port.
module wb_req_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    wb_req_t          mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags, guarded strobes and next occupancy.
    always_comb begin
        full       = (count_r == CNT_W'(DEPTH));
        empty      = (count_r == {CNT_W{1'b0}});
        push_ok_s  = push && !full;
        pop_ok_s   = pop && !empty;
        count_next = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        head       = mem_r[rd_ptr_r];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_ok_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_ok_s);
            count_r  <= count_next;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered mul/div results.
// Optional macro WB_ARB_SCOREBOARD_EN enables the pend_bits pending-write scoreboard.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_wr_en,
    input  logic [REG_ADDR_W-1:0] pipe_wr_addr,
    input  logic [REG_DATA_W-1:0] pipe_wr_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_addr,
    input  logic [REG_DATA_W-1:0] md_data,
    output logic                  md_ready,
    input  logic                  md_issue,
    input  logic [REG_ADDR_W-1:0] md_issue_addr,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [REG_DATA_W-1:0] rf_data,
    output logic [NUM_REGS-1:0]   pend_bits,
    output logic                  stall_req,
    output logic                  proto_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_t             fifo_head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CNT_W-1:0]    fifo_count_next_s;
    logic                push_s;
    logic                pop_s;
    logic                blocked_s;
    logic                we_nxt_s;
    wb_req_t             wb_nxt_s;
    logic [NUM_REGS-1:0] pend_nxt_s;
    logic                unused_s;

    logic                md_ready_r;
    logic                rf_we_r;
    logic [REG_ADDR_W-1:0] rf_addr_r;
    logic [REG_DATA_W-1:0] rf_data_r;
    logic [NUM_REGS-1:0] pend_r;
    logic                stall_req_r;
    logic                proto_err_r;
    logic [3:0]          starve_cnt_r;

    assign push_s = md_valid && md_ready_r;

    wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_data  ('{addr: md_addr, data: md_data}),
        .pop        (pop_s),
        .head       (fifo_head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count_next (fifo_count_next_s)
    );

    // Grant selection: the pipe always wins; a head matching the pipe address is killed (WAW).
    always_comb begin
        pop_s    = 1'b0;
        we_nxt_s = 1'b0;
        wb_nxt_s = '{addr: rf_addr_r, data: rf_data_r};
        if (pipe_wr_en) begin
            pop_s    = !fifo_empty_s && addr_writable(pipe_wr_addr) &&
                       (fifo_head_s.addr == pipe_wr_addr);
            we_nxt_s = addr_writable(pipe_wr_addr);
            wb_nxt_s = '{addr: pipe_wr_addr, data: pipe_wr_data};
        end else if (!fifo_empty_s) begin
            pop_s    = 1'b1;
            we_nxt_s = addr_writable(fifo_head_s.addr);
            wb_nxt_s = fifo_head_s;
        end else begin
            pop_s    = 1'b0;
            we_nxt_s = 1'b0;
        end
        blocked_s = !fifo_empty_s && !pop_s;
    end

`ifdef WB_ARB_SCOREBOARD_EN
    // Set applied after clear so an issue to the address being popped keeps its bit.
    assign pend_nxt_s = (pend_r & ~(pop_s ? (32'd1 << fifo_head_s.addr) : 32'd0)) |
                        ((md_issue && addr_writable(md_issue_addr)) ? (32'd1 << md_issue_addr) : 32'd0);
    assign unused_s   = fifo_full_s;
`else
    assign pend_nxt_s = {NUM_REGS{1'b0}};
    assign unused_s   = ^{fifo_full_s, md_issue, md_issue_addr};
`endif

    // Registered write port, ready and scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_r    <= 1'b0;
            rf_addr_r  <= {REG_ADDR_W{1'b0}};
            rf_data_r  <= {REG_DATA_W{1'b0}};
            md_ready_r <= 1'b0;
            pend_r     <= {NUM_REGS{1'b0}};
        end else begin
            rf_we_r    <= we_nxt_s;
            rf_addr_r  <= wb_nxt_s.addr;
            rf_data_r  <= wb_nxt_s.data;
            md_ready_r <= fifo_count_next_s < CNT_W'(FIFO_DEPTH);
            pend_r     <= pend_nxt_s;
        end
    end

    // Starvation counter: one-cycle stall request after STARVE_LIMIT blocked cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
            stall_req_r  <= 1'b0;
        end else if (blocked_s) begin
            if (starve_cnt_r == 4'(STARVE_LIMIT - 1)) begin
                starve_cnt_r <= 4'd0;
                stall_req_r  <= 1'b1;
            end else begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
                stall_req_r  <= 1'b0;
            end
        end else begin
            starve_cnt_r <= 4'd0;
            stall_req_r  <= 1'b0;
        end
    end

    // Sticky protocol error: the pipeline ignored a stall request.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_r <= 1'b0;
        end else if (stall_req_r && pipe_wr_en) begin
            proto_err_r <= 1'b1;
        end
    end

    assign md_ready  = md_ready_r;
    assign rf_we     = rf_we_r;
    assign rf_addr   = rf_addr_r;
    assign rf_data   = rf_data_r;
    assign pend_bits = pend_r;
    assign stall_req = stall_req_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] pend_bits;
    logic        stall_req;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

`ifdef WB_ARB_SCOREBOARD_EN
    localparam logic [31:0] PEND9 = 32'h0000_0200;
`else
    localparam logic [31:0] PEND9 = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_wr_en    (pipe_wr_en),
        .pipe_wr_addr  (pipe_wr_addr),
        .pipe_wr_data  (pipe_wr_data),
        .md_valid      (md_valid),
        .md_addr       (md_addr),
        .md_data       (md_data),
        .md_ready      (md_ready),
        .md_issue      (md_issue),
        .md_issue_addr (md_issue_addr),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .pend_bits     (pend_bits),
        .stall_req     (stall_req),
        .proto_err     (proto_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic en, input logic [4:0] addr, input logic [31:0] data);
        pipe_wr_en   = en;
        pipe_wr_addr = addr;
        pipe_wr_data = data;
    endtask

    task automatic md(input logic en, input logic [4:0] addr, input logic [31:0] data);
        md_valid = en;
        md_addr  = addr;
        md_data  = data;
    endtask

    initial begin
        reset = 1'b1;
        pipe(1'b0, 5'd0, 32'd0);
        md(1'b0, 5'd0, 32'd0);
        md_issue      = 1'b0;
        md_issue_addr = 5'd0;
        step();
        step();
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_rf_addr", 32'(rf_addr), 32'd0);
        check_eq("rst_rf_data", rf_data, 32'd0);
        check_eq("rst_pend", pend_bits, 32'd0);
        check_eq("rst_stall", 32'(stall_req), 32'd0);
        check_eq("rst_md_ready", 32'(md_ready), 32'd0);
        check_eq("rst_proto", 32'(proto_err), 32'd0);
        reset = 1'b0;
        step();
        check_eq("rel_md_ready", 32'(md_ready), 32'd1);

        // md write, pipe idle: visible two cycles after the handshake, one cycle wide
        md(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        md(1'b0, 5'd0, 32'd0);
        check_eq("md_lat_we_early", 32'(rf_we), 32'd0);
        step();
        check_eq("md_we", 32'(rf_we), 32'd1);
        check_eq("md_addr", 32'(rf_addr), 32'd5);
        check_eq("md_data", rf_data, 32'hDEAD_BEEF);
        step();
        check_eq("md_we_pulse", 32'(rf_we), 32'd0);

        // pipe addr 3 beats head addr 7
        md(1'b1, 5'd7, 32'h0000_0077);
        step();
        md(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd3, 32'h0000_0033);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        check_eq("prio_pipe_addr", 32'(rf_addr), 32'd3);
        check_eq("prio_pipe_data", rf_data, 32'h0000_0033);
        step();
        check_eq("prio_md_we", 32'(rf_we), 32'd1);
        check_eq("prio_md_addr", 32'(rf_addr), 32'd7);
        check_eq("prio_md_data", rf_data, 32'h0000_0077);
        step();
        check_eq("prio_idle", 32'(rf_we), 32'd0);

        // starvation: 4 blocked cycles -> stall_req, md written in the stall cycle
        md(1'b1, 5'd10, 32'h0000_00A0);
        pipe(1'b1, 5'd1, 32'h0000_0100);
        step();
        md(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pipe(1'b1, 5'(2 + i), 32'h0000_0200 + 32'(i));
            step();
            check_eq("starve_ramp", 32'(stall_req), 32'(i == 3));
        end
        pipe(1'b0, 5'd0, 32'd0);
        step();
        check_eq("starve_md_we", 32'(rf_we), 32'd1);
        check_eq("starve_md_addr", 32'(rf_addr), 32'd10);
        check_eq("starve_md_data", rf_data, 32'h0000_00A0);
        check_eq("starve_stall_drop", 32'(stall_req), 32'd0);
        check_eq("starve_no_proto", 32'(proto_err), 32'd0);

        // pipe ignores stall_req -> pipe still wins, proto_err sticks
        md(1'b1, 5'd12, 32'h0000_00C0);
        pipe(1'b1, 5'd1, 32'h0000_0101);
        step();
        md(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check_eq("proto_stall", 32'(stall_req), 32'd1);
        pipe(1'b1, 5'd2, 32'h0000_0222);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        check_eq("proto_err_set", 32'(proto_err), 32'd1);
        check_eq("proto_pipe_addr", 32'(rf_addr), 32'd2);
        check_eq("proto_pipe_data", rf_data, 32'h0000_0222);
        step();
        check_eq("proto_md_addr", 32'(rf_addr), 32'd12);
        check_eq("proto_md_data", rf_data, 32'h0000_00C0);
        check_eq("proto_sticky", 32'(proto_err), 32'd1);

        // writes to register 0 are consumed silently
        pipe(1'b1, 5'd0, 32'h0000_0005);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        check_eq("zero_pipe_we", 32'(rf_we), 32'd0);
        md(1'b1, 5'd0, 32'h0000_0006);
        step();
        md(1'b0, 5'd0, 32'd0);
        step();
        check_eq("zero_md_we", 32'(rf_we), 32'd0);
        step();
        check_eq("zero_md_drained", 32'(rf_we), 32'd0);

        // WAW kill on addr 9 with scoreboard bit
        md_issue      = 1'b1;
        md_issue_addr = 5'd9;
        step();
        md_issue      = 1'b0;
        md_issue_addr = 5'd0;
        check_eq("pend9_set", pend_bits, PEND9);
        md(1'b1, 5'd9, 32'h0000_0099);
        step();
        md(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd9, 32'h0000_0909);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        check_eq("waw_we", 32'(rf_we), 32'd1);
        check_eq("waw_data", rf_data, 32'h0000_0909);
        check_eq("waw_pend_clr", pend_bits, 32'd0);
        step();
        check_eq("waw_head_killed", 32'(rf_we), 32'd0);

        // back-pressure: third push refused, in-order drain
        md(1'b1, 5'd20, 32'h0000_0014);
        pipe(1'b1, 5'd1, 32'h0000_0111);
        step();
        check_eq("bp_ready_1", 32'(md_ready), 32'd1);
        md(1'b1, 5'd21, 32'h0000_0015);
        step();
        check_eq("bp_ready_full", 32'(md_ready), 32'd0);
        md(1'b1, 5'd22, 32'h0000_0016);
        step();
        check_eq("bp_ready_held", 32'(md_ready), 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        step();
        check_eq("bp_drain0_addr", 32'(rf_addr), 32'd20);
        check_eq("bp_drain0_data", rf_data, 32'h0000_0014);
        check_eq("bp_ready_back", 32'(md_ready), 32'd1);
        step();
        md(1'b0, 5'd0, 32'd0);
        check_eq("bp_drain1_addr", 32'(rf_addr), 32'd21);
        step();
        check_eq("bp_drain2_we", 32'(rf_we), 32'd1);
        check_eq("bp_drain2_addr", 32'(rf_addr), 32'd22);
        check_eq("bp_drain2_data", rf_data, 32'h0000_0016);
        step();
        check_eq("bp_empty", 32'(rf_we), 32'd0);

        // reset with two entries buffered
        md(1'b1, 5'd25, 32'h0000_0025);
        pipe(1'b1, 5'd1, 32'h0000_0123);
        md_issue      = 1'b1;
        md_issue_addr = 5'd25;
        step();
        md_issue = 1'b0;
        md(1'b1, 5'd26, 32'h0000_0026);
        step();
        md(1'b0, 5'd0, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        step();
        check_eq("mrst_we", 32'(rf_we), 32'd0);
        check_eq("mrst_pend", pend_bits, 32'd0);
        check_eq("mrst_ready", 32'(md_ready), 32'd0);
        check_eq("mrst_proto", 32'(proto_err), 32'd0);
        reset = 1'b0;
        step();
        check_eq("mrst_ready_rise", 32'(md_ready), 32'd1);
        check_eq("mrst_no_we0", 32'(rf_we), 32'd0);
        step();
        check_eq("mrst_no_we1", 32'(rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
